// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: stage payload layout, bubble encodings and the
// elastic-stage state enum.
package cpu_pipe_pkg;

  localparam int unsigned PIPE_DATA_W = 128;

  localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [2:0] EXE_RES_NOP = 3'b000;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] link;
    logic        delayslot;
  } id_ex_t;

  localparam int unsigned ID_EX_W = $bits(id_ex_t);

  localparam id_ex_t ID_EX_NOP = '{aluop: EXE_NOP_OP, alusel: EXE_RES_NOP, default: '0};

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} pipe_state_e;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Handshake control for pipe_stage_reg: valid bits, data-register load/select
// strobes and in_ready, either as a 2-entry skid FSM or a single register.
module pipe_skid_ctrl import cpu_pipe_pkg::*; #(
  parameter int unsigned SKID = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic out_valid,
  output logic load_main,
  output logic main_from_skid,
  output logic load_skid
);

  if (SKID != 0) begin : gen_skid
    pipe_state_e state_q, state_d;
    logic        in_ready_q;
    logic        in_xfer;

    assign in_xfer   = in_valid && in_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);

    always_comb begin
      state_d        = state_q;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
      unique case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d   = ST_FULL;
            load_main = 1'b1;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_ready) begin
            load_main = 1'b1;
          end else if (in_xfer) begin
            state_d   = ST_SKID;
            load_skid = 1'b1;
          end else if (out_ready) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_ready) begin
            state_d        = ST_FULL;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
      // Flush wins over any transfer in the same cycle.
      if (flush) begin
        state_d        = ST_EMPTY;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q    <= ST_EMPTY;
        in_ready_q <= 1'b1;
      end else begin
        state_q    <= state_d;
        in_ready_q <= (state_d != ST_SKID);
      end
    end
  end else begin : gen_single
    logic valid_q;
    logic in_xfer;

    assign in_ready       = !valid_q || out_ready;
    assign in_xfer        = in_valid && in_ready;
    assign out_valid      = valid_q;
    assign load_main      = in_xfer && !flush;
    assign main_from_skid = 1'b0;
    assign load_skid      = 1'b0;

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        valid_q <= 1'b0;
      end else if (in_xfer) begin
        valid_q <= 1'b1;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic elastic pipeline register with optional skid buffer and bubble muxing.
// Define PIPE_STAGE_PERF_EN to build the stall/bubble performance counters.
module pipe_stage_reg import cpu_pipe_pkg::*; #(
  parameter int unsigned          DATA_W    = PIPE_DATA_W,
  parameter logic [DATA_W-1:0]    NOP_VALUE = '0,
  parameter int unsigned          SKID      = 1,
  parameter int unsigned          CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              load_main;
  logic              main_from_skid;
  logic              load_skid;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;

  pipe_skid_ctrl #(
    .SKID(SKID)
  ) u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .out_ready     (out_ready),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .load_main     (load_main),
    .main_from_skid(main_from_skid),
    .load_skid     (load_skid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= NOP_VALUE;
      skid_q <= NOP_VALUE;
    end else begin
      if (load_main) main_q <= main_from_skid ? skid_q : in_data;
      if (load_skid) skid_q <= in_data;
    end
  end

  assign out_data = out_valid ? main_q : NOP_VALUE;

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CntOne = 1;

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] bubble_q;

  // Saturating; flush intentionally leaves the counts alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != '1)) stall_q <= stall_q + CntOne;
      if (!out_valid && out_ready && (bubble_q != '1)) bubble_q <= bubble_q + CntOne;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule
